// File: rtl/jtkiwi_shram_if.sv
// ---------------------------------------------------------------------------
// jtkiwi_shram_if
// Shared-RAM bus between the Kiwi main CPU, the sub/sound CPU and the
// arbitrated shared RAM.
//
// Signals (per port x = main / sub)
//   x_addr  [AW]  CPU address
//   x_din   [DW]  CPU write data
//   x_rnw         1 = read, 0 = write
//   x_cs          request; held until x_ok
//   x_dout  [DW]  read data returned to the CPU
//   x_ok          access complete; held while x_cs stays high
//   mshramen      high while the main port owns the RAM
//
// Modports
//   master : CPU side (drives requests, receives data/handshake)
//   slave  : RAM arbiter side
// ---------------------------------------------------------------------------
interface jtkiwi_shram_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic [AW-1:0] main_addr;
  logic [DW-1:0] main_din;
  logic          main_rnw;
  logic          main_cs;
  logic [DW-1:0] main_dout;
  logic          main_ok;

  logic [AW-1:0] sub_addr;
  logic [DW-1:0] sub_din;
  logic          sub_rnw;
  logic          sub_cs;
  logic [DW-1:0] sub_dout;
  logic          sub_ok;

  logic          mshramen;

  modport master (
    output main_addr, main_din, main_rnw, main_cs,
    output sub_addr,  sub_din,  sub_rnw,  sub_cs,
    input  main_dout, main_ok, sub_dout, sub_ok, mshramen
  );

  modport slave (
    input  main_addr, main_din, main_rnw, main_cs,
    input  sub_addr,  sub_din,  sub_rnw,  sub_cs,
    output main_dout, main_ok, sub_dout, sub_ok, mshramen
  );
endinterface

// File: rtl/jtkiwi_shram.sv
// ---------------------------------------------------------------------------
// jtkiwi_shram
// Arbitrated shared RAM (2^AW x DW) between the main CPU and the sub CPU.
// Requests from both ports are serialised onto one single-port RAM; each
// access takes an ACC cycle (RAM write / synchronous read) and a DONE cycle
// (data and ok returned). On a conflict the port not served last wins.
//
// Ports
//   clk   system clock
//   rstn  synchronous active-low reset
//   bus   shared-RAM bus (slave side): per-port addr/din/rnw/cs requests,
//         per-port dout/ok responses and the mshramen ownership flag
// All outputs are registered.
// ---------------------------------------------------------------------------
module jtkiwi_shram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  jtkiwi_shram_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ACC_M,
    DONE_M,
    ACC_S,
    DONE_S
  } state_t;

  state_t        state_q, state_d;
  logic          main_done_q, sub_done_q;
  logic          last_sub_q;          // 1: sub was served most recently
  logic          main_ok_q, sub_ok_q, mshramen_q;
  logic [DW-1:0] main_dout_q, sub_dout_q;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          rnw_q;
  logic [DW-1:0] ram_q;
  logic          ram_we;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // A port is pending while it requests and its current access has not
  // already been acknowledged; done clears only once cs has been dropped.
  logic main_pend, sub_pend;
  assign main_pend = bus.main_cs & ~main_done_q;
  assign sub_pend  = bus.sub_cs  & ~sub_done_q;

  // Next-state decision.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_d and no
    // latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (main_pend && (!sub_pend || last_sub_q)) state_d = ACC_M;
        else if (sub_pend)                          state_d = ACC_S;
      end
      ACC_M:   state_d = DONE_M;
      ACC_S:   state_d = DONE_S;
      DONE_M:  state_d = sub_pend  ? ACC_S : IDLE;
      DONE_S:  state_d = main_pend ? ACC_M : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q     <= IDLE;
      main_done_q <= 1'b0;
      sub_done_q  <= 1'b0;
      last_sub_q  <= 1'b1;
      main_ok_q   <= 1'b0;
      sub_ok_q    <= 1'b0;
      mshramen_q  <= 1'b0;
      main_dout_q <= '0;
      sub_dout_q  <= '0;
    end else begin
      state_q    <= state_d;
      mshramen_q <= (state_d == ACC_M) || (state_d == DONE_M);

      // ok falls (and the port re-arms) on the first edge that sees cs low.
      if (!bus.main_cs) begin
        main_ok_q   <= 1'b0;
        main_done_q <= 1'b0;
      end
      if (!bus.sub_cs) begin
        sub_ok_q   <= 1'b0;
        sub_done_q <= 1'b0;
      end

      unique case (state_q)
        DONE_M: begin
          if (rnw_q) main_dout_q <= ram_q;
          if (bus.main_cs) begin
            main_ok_q   <= 1'b1;
            main_done_q <= 1'b1;
          end
          last_sub_q <= 1'b0;
        end
        DONE_S: begin
          if (rnw_q) sub_dout_q <= ram_q;
          if (bus.sub_cs) begin
            sub_ok_q   <= 1'b1;
            sub_done_q <= 1'b1;
          end
          last_sub_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Request capture on grant; the granted port's request is registered on
  // the edge entering ACC_x.
  always_ff @(posedge clk) begin
    if (state_d == ACC_M) begin
      addr_q <= bus.main_addr;
      din_q  <= bus.main_din;
      rnw_q  <= bus.main_rnw;
    end else if (state_d == ACC_S) begin
      addr_q <= bus.sub_addr;
      din_q  <= bus.sub_din;
      rnw_q  <= bus.sub_rnw;
    end
  end

  // Single-port RAM. A write caught by a reset edge is dropped.
  assign ram_we = rstn & ~rnw_q & ((state_q == ACC_M) || (state_q == ACC_S));

  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; contents survive rstn, which also
    // lets it map onto block RAM.
    if (ram_we) mem[addr_q] <= din_q;
    ram_q <= mem[addr_q];
  end

  assign bus.main_dout = main_dout_q;
  assign bus.main_ok   = main_ok_q;
  assign bus.sub_dout  = sub_dout_q;
  assign bus.sub_ok    = sub_ok_q;
  assign bus.mshramen  = mshramen_q;

endmodule

// File: doc/jtkiwi_shram.md
# jtkiwi_shram

Arbitrated 8 kB shared RAM sitting between the main CPU and the sub CPU of the Kiwi core. It is the responder for both ends of the shared-RAM bus: the main CPU and the sub/sound CPU each issue address, data, read/write and chip-select requests. This block serialises those requests onto one single-port block RAM and returns data with a per-port ok handshake. It also drives the `mshramen` status, which flags main-side ownership of the RAM.

## Interface
Parameters
- AW, 13, address width (RAM depth 2^AW bytes)
- DW, 8, data width

Ports
- clk  in  1  system clock (24 MHz)
- rstn  in  1  reset, synchronous, active-low
- main_addr  in  AW  main CPU address
- main_din  in  DW  main CPU write data
- main_rnw  in  1  1 = read, 0 = write
- main_cs  in  1  main request; held until main_ok
- main_dout  out  DW  read data to main CPU
- main_ok  out  1  main access complete; held while main_cs stays high
- sub_addr  in  AW  sub CPU address
- sub_din  in  DW  sub CPU write data
- sub_rnw  in  1  1 = read, 0 = write
- sub_cs  in  1  sub request; held until sub_ok
- sub_dout  out  DW  read data to sub CPU
- sub_ok  out  1  sub access complete; held while sub_cs stays high
- mshramen  out  1  high while the main port owns the RAM (ACC_M or DONE_M)

## Operation
- FSM states: IDLE, ACC_M, DONE_M, ACC_S, DONE_S.
- Pending condition per port: `x_cs & ~x_done`. `x_done` is set when x_ok rises and cleared on any cycle with x_cs low. A new access therefore needs cs low for at least 1 cycle.
- Grant: only one port pending → that port wins. Both pending → the port not served last wins. `last` resets to sub, so main wins the first conflict.
- On grant, addr, din and rnw are registered; the requester must hold them stable anyway.
- ACC_x: RAM write enable = ~rnw_reg, or synchronous read issued; next state DONE_x.
- DONE_x:
  - Read: RAM q is latched into x_dout.
  - Write: x_dout is unchanged.
  - x_ok is set only if x_cs is still high.
  - `last` ← x.
  - Next state is ACC_y if the other port y is pending, otherwise IDLE.
- cs dropped mid-access: the access completes and any write is committed. ok is not raised and done is not set.
- Serialisation guarantees coherence: a write from one port followed by a read from the other at the same address returns the new data.
- x_ok falls on the first clock edge that samples x_cs low.
- Reset (rstn low at an edge):
  - state → IDLE; main_ok, sub_ok, mshramen → 0; main_dout, sub_dout → 0.
  - done flags → 0; last → sub.
  - An in-flight write in ACC_x at the reset edge is suppressed (we gated by rstn).
  - RAM contents are not cleared.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Uncontended latency: x_cs sampled high at edge E0 (IDLE→ACC_x), RAM access at E1 (→DONE_x), x_ok and x_dout valid after E2.
  - ok is high 3 edges after cs is first sampled.
- Back-to-back alternate ports: ACC_M, DONE_M, ACC_S, DONE_S gives one access per 2 cycles.
- Same port repeating: at least 4 cycles per access (cs low 1 cycle, then 3).
- Worst-case wait under contention: 2 extra cycles, since the other port's access is in flight.
- mshramen is high exactly during the ACC_M and DONE_M cycles.

## Test plan
- Reset then single main write followed by main read:
  - Main writes 0xA5 to 0x0123; main_ok rises 3 edges after cs and mshramen is high for 2 cycles.
  - Main then reads 0x0123; main_dout = 0xA5.
- Simultaneous first requests: main and sub reads raised on the same cycle with both pending.
  - Main is served first (ok at +3), sub next (ok at +5).
  - A second simultaneous pair is served sub first.
- Cross-port coherence: sub writes 0x3C to 0x1FFF while main reads 0x1FFF, same cycle, after a sub-last history.
  - Main is served first and returns the old value.
  - A repeat main read returns 0x3C.
- cs held after ok: main_cs kept high for 10 cycles after main_ok.
  - No second access occurs: mshramen stays low and RAM is unchanged.
  - main_ok falls on the edge after cs drops.
- cs withdrawn mid-access: sub write of 0x77 to 0x0040, sub_cs dropped in ACC_S.
  - sub_ok never rises; a later read of 0x0040 returns 0x77.
- Reset in ACC_M during a write of 0xFF to 0x0010:
  - All outputs are 0 after the reset edge.
  - A read of 0x0010 returns its pre-write value; the FSM accepts a new request from IDLE.
